// File: rtl/seq_alu_hs.sv
// seq_alu_hs: registered ALU with valid/ready handshakes.
// Shifts run one bit per cycle; packed-BCD add runs one digit per cycle.
module seq_alu_hs #(
  parameter int WIDTH = 8,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic [3:0]       sel,
  input  logic [SHW-1:0]   sh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             err
);
  localparam int DIGITS = WIDTH / 4;
  localparam int DW = $clog2(DIGITS + 1);
  localparam int CW = (SHW > DW) ? SHW : DW;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SHL = 4'h5;
  localparam logic [3:0] OP_SHR = 4'h6;
  localparam logic [3:0] OP_ROL = 4'h7;
  localparam logic [3:0] OP_BCD = 4'h8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q, out_q;
  logic [CW-1:0]    cnt_q;
  logic             cy_q, bad_q;
  logic             carry_q, zero_q, err_q;

  logic [WIDTH:0]   sum_w, dif_w;
  logic [WIDTH-1:0] imm_d, step_d;
  logic             imm_c_d, imm_e_d, imm_go_d;
  logic             bcd_bad_d, step_c_d;
  logic [5:0]       dsum;
  logic [3:0]       dig;

  always_comb begin
    sum_w = {1'b0, inA} + {1'b0, inB};
    dif_w = {1'b0, inA} - {1'b0, inB};
    imm_d = '0;
    imm_c_d = 1'b0;
    imm_e_d = 1'b0;
    imm_go_d = 1'b1;
    bcd_bad_d = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (inA[4*i +: 4] > 4'd9 || inB[4*i +: 4] > 4'd9)
        bcd_bad_d = 1'b1;
    end
    case (sel)
      OP_ADD: begin
        imm_d = sum_w[WIDTH-1:0];
        imm_c_d = sum_w[WIDTH];
      end
      OP_SUB: begin
        imm_d = dif_w[WIDTH-1:0];
        imm_c_d = dif_w[WIDTH];
      end
      OP_AND: imm_d = inA & inB;
      OP_OR:  imm_d = inA | inB;
      OP_XOR: imm_d = inA ^ inB;
      OP_SHL, OP_SHR, OP_ROL: begin
        imm_d = inA;
        imm_go_d = (sh == '0);
      end
      OP_BCD: imm_go_d = 1'b0;
      default: imm_e_d = 1'b1;
    endcase
  end

  // BCD digits enter at the top of a_q so the result lands in order
  always_comb begin
    dsum = 6'(a_q[3:0]) + 6'(b_q[3:0]) + 6'(cy_q);
    dig = dsum[3:0];
    step_d = '0;
    step_c_d = 1'b0;
    unique case (1'b1)
      op_q == OP_SHL: begin
        step_d = a_q << 1;
        step_c_d = a_q[WIDTH-1];
      end
      op_q == OP_SHR: begin
        step_d = a_q >> 1;
        step_c_d = a_q[0];
      end
      op_q == OP_ROL: begin
        step_d = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
      end
      default: begin
        if (dsum > 6'd9) begin
          dig = dsum[3:0] + 4'd6;
          step_c_d = 1'b1;
        end
        step_d = (a_q >> 4) | (WIDTH'(dig) << (WIDTH - 4));
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      bad_q   <= 1'b0;
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q  <= sel;
            a_q   <= inA;
            b_q   <= inB;
            cy_q  <= 1'b0;
            bad_q <= (sel == OP_BCD) && bcd_bad_d;
            cnt_q <= (sel == OP_BCD) ? CW'(DIGITS) : CW'(sh);
            if (imm_go_d) begin
              out_q   <= imm_d;
              carry_q <= imm_c_d;
              zero_q  <= (imm_d == '0);
              err_q   <= imm_e_d;
              state_q <= S_DONE;
            end else begin
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          a_q   <= step_d;
          b_q   <= b_q >> 4;
          cy_q  <= step_c_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            out_q   <= step_d;
            carry_q <= step_c_d;
            zero_q  <= (step_d == '0);
            err_q   <= bad_q;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready)
            state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu_hs.sv
// tb_seq_alu_hs: 8- and 16-bit instances checked against
// an arithmetic reference model, cycle by cycle.
module tb_seq_alu_hs;
  typedef struct {
    logic [31:0] r;
    logic        c;
    logic        z;
    logic        e;
    int          lat;
  } exp_t;

  logic clk, rst_n;
  logic [1:0] iv, ordy, irdy, ov, rc, rz, re;
  logic [1:0][31:0] ia, ib, ro;
  logic [1:0][3:0] isel, ish;

  logic rdy8, ov8, c8, z8, e8;
  logic rdy16, ov16, c16, z16, e16;
  logic [7:0] o8;
  logic [15:0] o16;

  int total = 0;
  int bad = 0;

  exp_t ex[2];
  exp_t p;
  bit [1:0] pend, seen;
  int cyc[2];
  logic prev_rst = 1'b0;

  seq_alu_hs #(.WIDTH(8), .SHW(4)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(rdy8),
    .inA(ia[0][7:0]), .inB(ib[0][7:0]),
    .sel(isel[0]), .sh(ish[0]),
    .out_valid(ov8), .out_ready(ordy[0]),
    .out(o8), .carry(c8), .zero(z8), .err(e8)
  );

  seq_alu_hs #(.WIDTH(16), .SHW(4)) u16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(rdy16),
    .inA(ia[1][15:0]), .inB(ib[1][15:0]),
    .sel(isel[1]), .sh(ish[1]),
    .out_valid(ov16), .out_ready(ordy[1]),
    .out(o16), .carry(c16), .zero(z16), .err(e16)
  );

  always_comb begin
    irdy = {rdy16, rdy8};
    ov = {ov16, ov8};
    rc = {c16, c8};
    rz = {z16, z8};
    re = {e16, e8};
    ro[0] = 32'(o8);
    ro[1] = 32'(o16);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int w, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] s,
                                 input int sh);
    exp_t x;
    logic [63:0] m, wide;
    int k, da, db, cc, t;
    m = (64'd1 << w) - 64'd1;
    x.r = '0; x.c = 1'b0; x.e = 1'b0; x.lat = 1;
    case (s)
      4'h0: begin
        wide = 64'(a) + 64'(b);
        x.r = 32'(wide & m);
        x.c = wide[w];
      end
      4'h1: begin
        x.r = 32'((64'(a) - 64'(b)) & m);
        x.c = (a < b);
      end
      4'h2: x.r = a & b;
      4'h3: x.r = a | b;
      4'h4: x.r = a ^ b;
      4'h5: begin
        x.r = (sh >= w) ? 32'd0 : 32'((64'(a) << sh) & m);
        x.c = (sh > 0 && sh <= w) ? a[w-sh] : 1'b0;
        x.lat = 1 + sh;
      end
      4'h6: begin
        x.r = (sh >= w) ? 32'd0 : (a >> sh);
        x.c = (sh > 0 && sh <= w) ? a[sh-1] : 1'b0;
        x.lat = 1 + sh;
      end
      4'h7: begin
        k = sh % w;
        wide = 64'(a);
        x.r = 32'(((wide << k) | (wide >> (w - k))) & m);
        x.lat = 1 + sh;
      end
      4'h8: begin
        cc = 0;
        for (int i = 0; i < w / 4; i++) begin
          da = int'((a >> (4 * i)) & 32'hF);
          db = int'((b >> (4 * i)) & 32'hF);
          if (da > 9 || db > 9) x.e = 1'b1;
          t = da + db + cc;
          if (t > 9) begin t = t + 6; cc = 1; end
          else cc = 0;
          x.r = x.r | (32'(t & 15) << (4 * i));
        end
        x.c = (cc != 0);
        x.lat = 1 + w / 4;
      end
      default: x.e = 1'b1;
    endcase
    x.z = (x.r == 0);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exv);
    total++;
    if (act !== exv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exv);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!prev_rst) begin
        chk("rst_out", ro[d], 32'd0);
        chk("rst_valid", 32'(ov[d]), 32'd0);
        chk("rst_ready", 32'(irdy[d]), 32'd1);
        chk("rst_flags", {29'd0, rc[d], rz[d], re[d]}, 32'd0);
      end else if (pend[d]) begin
        cyc[d]++;
        if (ov[d]) begin
          if (!seen[d]) begin
            chk("latency", 32'(cyc[d]), 32'(ex[d].lat));
            seen[d] = 1'b1;
          end
          chk("out", ro[d], ex[d].r);
          chk("carry", 32'(rc[d]), 32'(ex[d].c));
          chk("zero", 32'(rz[d]), 32'(ex[d].z));
          chk("err", 32'(re[d]), 32'(ex[d].e));
          chk("done_ready", 32'(irdy[d]), 32'd0);
          if (ordy[d]) pend[d] = 1'b0;
        end else begin
          chk("busy_ready", 32'(irdy[d]), 32'd0);
          if (cyc[d] > 60) begin
            total++;
            bad++;
            $display("FAIL done_timeout d=%0d: out_valid=0 want 1", d);
            pend[d] = 1'b0;
          end
        end
      end else begin
        chk("idle_valid", 32'(ov[d]), 32'd0);
        chk("idle_ready", 32'(irdy[d]), 32'd1);
      end
      if (!rst_n) begin
        pend[d] = 1'b0;
      end else if (!pend[d] && iv[d] && irdy[d]) begin
        ex[d] = model(d == 0 ? 8 : 16, ia[d], ib[d], isel[d], int'(ish[d]));
        pend[d] = 1'b1;
        seen[d] = 1'b0;
        cyc[d] = 0;
      end
    end
    prev_rst = rst_n;
  end

  task automatic run(input int d, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] s, input logic [3:0] shv,
                     input int hold);
    int n;
    n = 0;
    while (!irdy[d] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!irdy[d]) begin
      total++; bad++;
      $display("FAIL accept_wait d=%0d: in_ready=0 want 1", d);
      return;
    end
    ia[d] = a; ib[d] = b; isel[d] = s; ish[d] = shv;
    iv[d] = 1'b1;
    ordy[d] = (hold == 0);
    @(posedge clk); #1;
    iv[d] = 1'b0;
    ia[d] = ~a; ib[d] = a ^ b; isel[d] = ~s; ish[d] = ~shv;
    n = 0;
    while (!ov[d] && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ov[d]) begin
      total++; bad++;
      $display("FAIL result_wait d=%0d: out_valid=0 want 1", d);
      ordy[d] = 1'b1;
      return;
    end
    if (hold > 0) begin
      repeat (hold) begin
        iv[d] = 1'b1;
        ia[d] = $urandom;
        ib[d] = $urandom;
        @(posedge clk); #1;
      end
      iv[d] = 1'b0;
      ordy[d] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic pin(input string nm, input logic [31:0] act,
                     input logic [31:0] exv);
    chk(nm, act, exv);
  endtask

  initial begin
    rst_n = 1'b0;
    iv = '0; ordy = 2'b11;
    ia = '0; ib = '0; isel = '0; ish = '0;
    pend = '0; seen = '0;
    cyc[0] = 0; cyc[1] = 0;

    p = model(8, 32'h15, 32'h27, 4'h8, 0);
    pin("pin_bcd_r", p.r, 32'h42);
    pin("pin_bcd_lat", 32'(p.lat), 32'd3);
    p = model(8, 32'h99, 32'h01, 4'h8, 0);
    pin("pin_bcd_cz", {30'd0, p.c, p.z}, 32'd3);
    p = model(8, 32'h0F, 32'h01, 4'h8, 0);
    pin("pin_bcd_err", 32'(p.e), 32'd1);
    p = model(8, 32'h01, 32'h02, 4'h1, 0);
    pin("pin_sub", {p.r[30:0], p.c}, {31'hFF, 1'b1});
    p = model(8, 32'h01, 32'h00, 4'h5, 4);
    pin("pin_shl", p.r, 32'h10);
    pin("pin_shl_lat", 32'(p.lat), 32'd5);
    p = model(8, 32'h81, 32'h00, 4'h7, 9);
    pin("pin_rol", p.r, 32'h03);
    p = model(16, 32'h9999, 32'h0001, 4'h8, 0);
    pin("pin_bcd16", {p.r[30:0], p.c}, {31'h0, 1'b1});
    pin("pin_bcd16_lat", 32'(p.lat), 32'd5);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run(0, 32'h0F, 32'h0F, 4'h0, 4'h0, 0);
    run(0, 32'hFF, 32'h01, 4'h0, 4'h0, 0);
    run(0, 32'h01, 32'h02, 4'h1, 4'h0, 0);
    run(0, 32'hF0, 32'h3C, 4'h2, 4'h0, 0);
    run(0, 32'hF0, 32'h3C, 4'h3, 4'h0, 0);
    run(0, 32'hF0, 32'h3C, 4'h4, 4'h0, 0);
    run(0, 32'h01, 32'h00, 4'h5, 4'h4, 0);
    run(0, 32'h81, 32'h00, 4'h6, 4'h1, 0);
    run(0, 32'h81, 32'h00, 4'h7, 4'h9, 0);
    run(0, 32'h81, 32'h00, 4'h5, 4'h0, 0);
    run(0, 32'hFF, 32'h00, 4'h5, 4'hC, 0);
    run(0, 32'h80, 32'h00, 4'h6, 4'h8, 0);
    run(0, 32'h15, 32'h27, 4'h8, 4'h0, 0);
    run(0, 32'h99, 32'h01, 4'h8, 4'h0, 0);
    run(0, 32'h0F, 32'h01, 4'h8, 4'h0, 0);
    run(0, 32'h12, 32'h34, 4'h0, 4'h0, 5);
    run(0, 32'h5A, 32'h5A, 4'hF, 4'h0, 0);
    run(0, 32'h80, 32'h40, 4'h9, 4'h3, 0);

    run(1, 32'h9999, 32'h0001, 4'h8, 4'h0, 0);
    run(1, 32'hFFFF, 32'h0001, 4'h0, 4'h0, 0);
    run(1, 32'h8001, 32'h0000, 4'h7, 4'hF, 0);
    run(1, 32'h1234, 32'h0999, 4'h8, 4'h0, 0);

    ia[0] = 32'h15; ib[0] = 32'h27; isel[0] = 4'h8; ish[0] = 4'h0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    run(0, 32'h33, 32'h44, 4'h0, 4'h0, 0);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seq_alu_hs.md
Name: seq_alu_hs

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU/shifter (inA, inB, sel, sh → out).
- Adds valid/ready handshakes on input and output, flag outputs, and iterative multi-cycle operations:
  - barrel-free shifts/rotate, one bit per cycle;
  - packed-BCD add, one digit per cycle.
- Sits between an operand source and a result consumer in datapath experiments; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of 4 and ≥ 4.
- SHW, 4, width of shift-amount input sh.
- DIGITS, WIDTH/4, BCD digit count (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  block can accept an operation.
- inA  in  WIDTH  operand A.
- inB  in  WIDTH  operand B.
- sel  in  4  opcode.
- sh  in  SHW  shift/rotate amount.
- out_valid  out  1  result held on out.
- out_ready  in  1  consumer accepts result.
- out  out  WIDTH  result.
- carry  out  1  carry (ADD/BCDADD), borrow (SUB), last bit shifted out (SHL/SHR), else 0.
- zero  out  1  out == 0.
- err  out  1  illegal opcode, or non-BCD digit (>9) in either operand for BCDADD.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE; out=0, carry=0, zero=0, err=0, out_valid=0; in_ready=1 the following cycle.
  - Reset mid-operation aborts it with no result produced.
- States:
  - IDLE: in_ready=1. Accept when in_valid&in_ready; latch inA, inB, sel, sh.
  - BUSY: iterative work; in_ready=0.
  - DONE: out_valid=1; out/flags stable until handshake. out_ready=1 → IDLE next cycle.
  - No accept in the same cycle as result release (in_ready only in IDLE).
- Opcodes:
  - 0000 ADD: {carry,out} = A+B.
  - 0001 SUB: out = A−B mod 2^WIDTH; carry = (A<B).
  - 0010 AND.
  - 0011 OR.
  - 0100 XOR.
  - 0101 SHL logical, by sh.
  - 0110 SHR logical, by sh.
  - 0111 ROL rotate left, by sh (carry=0).
  - 1000 BCDADD packed BCD.
  - Others: out=0, err=1, carry=0.
- Latency, counted from accept edge to first cycle out_valid=1:
  - ADD/SUB/logic/illegal: IDLE→DONE, latency 1.
  - Shifts/rotate: counter loads sh; each BUSY cycle shifts 1 bit and decrements; DONE when counter reaches 0. sh=0 → straight to DONE, out=A, carry=0. Latency = 1+sh; max 1+(2^SHW−1).
  - Shift amounts ≥ WIDTH are legal: SHL/SHR → 0; ROL wraps modulo WIDTH naturally.
  - BCDADD: one digit per BUSY cycle, LSD first, DIGITS cycles. Per digit: s = a+b+c; if s>9, s+=6 and c=1, else c=0. Final c → carry. Latency = 1+DIGITS (3 for WIDTH=8).
  - BCDADD with non-BCD digit: computation proceeds with the same rule; err=1.
- Flags:
  - zero is derived from the final out.
  - err/carry/zero are registered with out and valid only while out_valid=1.
- Input signals are ignored outside the accept cycle; changing inA/inB/sel/sh while BUSY has no effect.
- Output backpressure: DONE held indefinitely while out_ready=0; values unchanged.

Test Plan:
- Reset: hold rst_n=0 two cycles, then release → out=0, out_valid=0, in_ready=1, flags 0. Assert rst_n=0 during BCDADD BUSY → IDLE next cycle, no out_valid.
- ADD, with out_ready=1:
  - A=0x0F, B=0x0F → out=0x1E, carry=0, latency 1.
  - A=0xFF, B=0x01 → out=0x00, carry=1, zero=1.
  - SUB A=0x01, B=0x02 → out=0xFF, carry=1.
- SHL A=0x01, sh=4 → out=0x10, latency 5, in_ready=0 for 4 cycles.
  - SHR A=0x81, sh=1 → out=0x40, carry=1.
  - ROL A=0x81, sh=9 → out=0x03.
  - sh=0 → out=A, latency 1.
- BCDADD: 0x15+0x27 → 0x42, carry=0, latency 3; 0x99+0x01 → 0x00, carry=1, zero=1; 0x0F+0x01 → err=1.
- Backpressure: out_ready=0 for 5 cycles after ADD completes → out/flags stable, in_valid ignored; out_ready=1 → IDLE next cycle, next op accepted; opcode 1111 → out=0, err=1.
- WIDTH=16 instance: BCDADD 0x9999+0x0001 → 0x0000, carry=1, latency 5; ADD 0xFFFF+0x0001 → carry=1.
